memarb2: RTL and testbench
==========================

# memarb2

Two-bank memory arbiter between the pipeline's memory-operation stage and one secondary agent (loader/debug DMA). Each cycle it grants each bank to at most one requester and drives that bank's enable, write strobe, address and write data. It steers the one-cycle-latency read data back to the owner and stalls the pipeline when it loses a bank. The secondary agent is protected from starvation by a bounded wait counter.

## Interface
- STARVE_MAX, 8: consecutive blocked cycles after which the agent is forced to win; legal range 1..255.
- iw_clk  in  1  clock.
- iw_rst  in  1  reset, synchronous, active-low; sampled on rising iw_clk.
- iw_p_req / iw_p_mp / iw_p_we  in  1 each  pipeline access request / bank select / write.
- iw_p_addr  in  `SIZE_ADDR  pipeline address.
- iw_p_wdata  in  `SIZE_DATA  pipeline write data.
- ow_p_stall  out  1  pipeline must hold its request this cycle.
- ow_p_rvalid  out  1  pipeline read data valid.
- ow_p_rdata  out  `SIZE_DATA  pipeline read data.
- iw_x_req / iw_x_mp / iw_x_we  in  1 each  agent request / bank / write.
- iw_x_addr  in  `SIZE_ADDR  agent address.
- iw_x_wdata  in  `SIZE_DATA  agent write data.
- ow_x_gnt  out  1  agent request accepted this cycle.
- ow_x_rvalid  out  1  agent read data valid.
- ow_x_rdata  out  `SIZE_DATA  agent read data.
- ow_mem_en[0:1] / ow_mem_we[0:1]  out  1 each  bank enable / write.
- ow_mem_addr[0:1]  out  `SIZE_ADDR  bank address.
- ow_mem_wdata[0:1]  out  `SIZE_DATA  bank write data.
- iw_mem_rdata[0:1]  in  `SIZE_DATA  bank read data, valid one cycle after an enabled read.

## Operation
- Grant logic is combinational on the current requests and state.
- Different banks (iw_p_mp != iw_x_mp): both requesters are granted. ow_p_stall=0, ow_x_gnt=1.
- Same bank: the winner is chosen by the FSM; the loser is stalled (pipeline) or left ungranted (agent).
- Requesters hold req/mp/we/addr/wdata stable until accepted. The agent may not withdraw before gnt.
- FSM states:
  - S_IDLE: no agent backlog. A conflict goes to the pipeline. If iw_x_req is not granted, load cnt=1 and go to S_WAIT.
  - S_WAIT: the pipeline wins conflicts and cnt increments per blocked cycle. An agent grant returns to S_IDLE. If cnt reaches STARVE_MAX while still blocked, go to S_FORCE.
  - S_FORCE: the agent wins its bank unconditionally. ow_p_stall=1 if the pipeline targets the same bank. Return to S_IDLE after one cycle; the agent is granted in that cycle by construction.
- Read return: per bank, a registered owner tag {valid, is_x} captures each enabled read. Next cycle, iw_mem_rdata[b] goes to the owner's rdata with rvalid=1.
- Writes produce no rvalid.
- Both requesters reading different banks in the same cycle: both rvalid assert together next cycle.
- Unselected rdata outputs hold their last value.
- When iw_rst=0, all grants are forced off: ow_mem_en=0, ow_mem_we=0, ow_p_stall=0, ow_x_gnt=0.

## Timing
- Reset values: FSM=S_IDLE, cnt=0, owner tags invalid, ow_p_rvalid=0, ow_x_rvalid=0, ow_p_rdata=0, ow_x_rdata=0.
- Reset asserted mid-operation: an in-flight read return is dropped, so no rvalid appears the next cycle.
- Grant to memory strobe has zero latency. Grant to rvalid takes 1 cycle.
- The agent's worst-case wait under continuous conflict is exactly STARVE_MAX cycles. It is granted in cycle STARVE_MAX+1 after the request is first seen.
- cnt is 8 bits and saturates at STARVE_MAX; it never wraps.

## Configuration
- MEMARB_STARVE_EN defined: S_WAIT/S_FORCE and cnt are present as described.
- MEMARB_STARVE_EN undefined: strict pipeline priority; the FSM and cnt are removed. The agent is granted only when there is no conflict or iw_p_req=0.

## Structure
- Shared header src/memarb.vh holds:
  - FSM state encodings (S_IDLE=2'd0, S_WAIT=2'd1, S_FORCE=2'd2);
  - owner-tag width;
  - default STARVE_MAX.
- Sizes come from src/sizes.vh.
- Sub-module memarb_bank, instantiated twice, contains one bank's request mux, owner-tag register and rdata steering. The top level holds the FSM and conflict detect.

## Test plan
- P read bank0 addr 0x10 and X write bank1 addr 0x20 data 0xBEEF, same cycle:
  - both strobes assert, stall=0, gnt=1;
  - P rvalid next cycle with the bank0 data.
- P and X both reading bank1, STARVE_MAX=8, P requesting continuously:
  - X gnt=0 for cycles 1..8;
  - in cycle 9, gnt=1 and stall=1;
  - X rvalid in cycle 10.
- Same as the previous scenario with MEMARB_STARVE_EN undefined: X gnt stays 0 for all 50 cycles; it rises the cycle after iw_p_req drops.
- X read bank0 granted, iw_rst=0 in the following cycle: ow_x_rvalid stays 0, FSM=S_IDLE, all outputs at their reset values.
- Back-to-back P reads alternating bank0/bank1 at 0x0..0x7 with no X traffic: stall never asserts, and rvalid is continuous with the data in order.

Source files
------------

// File: rtl/memarb2_pkg.sv
// Shared types and constants for the two-bank memory arbiter.
// Replaces the old memarb.vh / sizes.vh headers.
package memarb2_pkg;

    localparam int unsigned SIZE_ADDR      = 16;
    localparam int unsigned SIZE_DATA      = 32;
    localparam int unsigned STARVE_MAX_DEF = 8;
    localparam int unsigned CNT_W          = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    // Per-bank owner of an in-flight read: {valid, is_x}
    typedef struct packed {
        logic valid;
        logic is_x;
    } owner_tag_t;

    localparam int unsigned TAG_W = $bits(owner_tag_t);

endpackage

// File: rtl/memarb2_if.sv
// Bus bundle between pipeline, secondary agent, the two memory banks and memarb2.
// slave = arbiter side, master = the requesters/memory side.
interface memarb2_if;
    import memarb2_pkg::*;

    logic                 iw_p_req;
    logic                 iw_p_mp;
    logic                 iw_p_we;
    logic [SIZE_ADDR-1:0] iw_p_addr;
    logic [SIZE_DATA-1:0] iw_p_wdata;
    logic                 ow_p_stall;
    logic                 ow_p_rvalid;
    logic [SIZE_DATA-1:0] ow_p_rdata;

    logic                 iw_x_req;
    logic                 iw_x_mp;
    logic                 iw_x_we;
    logic [SIZE_ADDR-1:0] iw_x_addr;
    logic [SIZE_DATA-1:0] iw_x_wdata;
    logic                 ow_x_gnt;
    logic                 ow_x_rvalid;
    logic [SIZE_DATA-1:0] ow_x_rdata;

    logic                 ow_mem_en    [0:1];
    logic                 ow_mem_we    [0:1];
    logic [SIZE_ADDR-1:0] ow_mem_addr  [0:1];
    logic [SIZE_DATA-1:0] ow_mem_wdata [0:1];
    logic [SIZE_DATA-1:0] iw_mem_rdata [0:1];

    modport slave (
        input  iw_p_req, iw_p_mp, iw_p_we, iw_p_addr, iw_p_wdata,
        output ow_p_stall, ow_p_rvalid, ow_p_rdata,
        input  iw_x_req, iw_x_mp, iw_x_we, iw_x_addr, iw_x_wdata,
        output ow_x_gnt, ow_x_rvalid, ow_x_rdata,
        output ow_mem_en, ow_mem_we, ow_mem_addr, ow_mem_wdata,
        input  iw_mem_rdata
    );

    modport master (
        output iw_p_req, iw_p_mp, iw_p_we, iw_p_addr, iw_p_wdata,
        input  ow_p_stall, ow_p_rvalid, ow_p_rdata,
        output iw_x_req, iw_x_mp, iw_x_we, iw_x_addr, iw_x_wdata,
        input  ow_x_gnt, ow_x_rvalid, ow_x_rdata,
        input  ow_mem_en, ow_mem_we, ow_mem_addr, ow_mem_wdata,
        output iw_mem_rdata
    );

endinterface

// File: rtl/memarb_bank.sv
// One memory bank: request mux between pipeline and agent, read owner tag,
// and per-requester read-return hit flags.
module memarb_bank
    import memarb2_pkg::*;
(
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 p_sel,
    input  logic                 x_sel,
    input  logic                 p_we,
    input  logic                 x_we,
    input  logic [SIZE_ADDR-1:0] p_addr,
    input  logic [SIZE_ADDR-1:0] x_addr,
    input  logic [SIZE_DATA-1:0] p_wdata,
    input  logic [SIZE_DATA-1:0] x_wdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [SIZE_ADDR-1:0] mem_addr,
    output logic [SIZE_DATA-1:0] mem_wdata,
    output logic                 p_hit,
    output logic                 x_hit
);

    owner_tag_t tag_q;

    assign mem_en    = p_sel | x_sel;
    assign mem_we    = x_sel ? x_we    : (p_sel & p_we);
    assign mem_addr  = x_sel ? x_addr  : p_addr;
    assign mem_wdata = x_sel ? x_wdata : p_wdata;

    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            tag_q <= '0;
        end else begin
            tag_q.valid <= mem_en & ~mem_we;
            tag_q.is_x  <= x_sel;
        end
    end

    // Gating with reset drops a return whose read was issued just before reset
    assign p_hit = iw_rst & tag_q.valid & ~tag_q.is_x;
    assign x_hit = iw_rst & tag_q.valid &  tag_q.is_x;

endmodule

// File: rtl/memarb2.sv
// Two-bank arbiter between the pipeline memory stage and a secondary agent.
// MEMARB_STARVE_EN enables the bounded-wait anti-starvation FSM; otherwise strict pipeline priority.
module memarb2
    import memarb2_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic     iw_clk,
    input  logic     iw_rst,
    memarb2_if.slave mb
);

    logic                 conflict;
    logic                 x_win;
    logic                 p_stall;
    logic                 x_gnt;
    logic                 p_hit [0:1];
    logic                 x_hit [0:1];
    logic [SIZE_DATA-1:0] p_hold_q;
    logic [SIZE_DATA-1:0] x_hold_q;

    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve
        $error("memarb2: STARVE_MAX must be in 1..255");
    end

    assign conflict = mb.iw_p_req & mb.iw_x_req & (mb.iw_p_mp == mb.iw_x_mp);

`ifdef MEMARB_STARVE_EN
    localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_win   = 1'b0;
        cnt_inc = (cnt_q == SMAX) ? SMAX : cnt_q + 8'd1;
        case (state_q)
            S_IDLE: begin
                if (conflict) begin
                    cnt_d   = 8'd1;
                    state_d = (SMAX == 8'd1) ? S_FORCE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!conflict) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == SMAX) state_d = S_FORCE;
                end
            end
            S_FORCE: begin
                x_win   = 1'b1;
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end
`else
    assign x_win = 1'b0;
`endif

    assign x_gnt   = iw_rst & mb.iw_x_req & (~conflict | x_win);
    assign p_stall = iw_rst & conflict & x_win;

    assign mb.ow_x_gnt   = x_gnt;
    assign mb.ow_p_stall = p_stall;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic p_sel, x_sel;

        assign p_sel = iw_rst & mb.iw_p_req & (mb.iw_p_mp == 1'(b)) & ~p_stall;
        assign x_sel = x_gnt & (mb.iw_x_mp == 1'(b));

        memarb_bank u_bank (
            .iw_clk    (iw_clk),
            .iw_rst    (iw_rst),
            .p_sel     (p_sel),
            .x_sel     (x_sel),
            .p_we      (mb.iw_p_we),
            .x_we      (mb.iw_x_we),
            .p_addr    (mb.iw_p_addr),
            .x_addr    (mb.iw_x_addr),
            .p_wdata   (mb.iw_p_wdata),
            .x_wdata   (mb.iw_x_wdata),
            .mem_en    (mb.ow_mem_en[b]),
            .mem_we    (mb.ow_mem_we[b]),
            .mem_addr  (mb.ow_mem_addr[b]),
            .mem_wdata (mb.ow_mem_wdata[b]),
            .p_hit     (p_hit[b]),
            .x_hit     (x_hit[b])
        );
    end

    // Each requester hits at most one bank per cycle; otherwise the last value is held
    assign mb.ow_p_rvalid = p_hit[0] | p_hit[1];
    assign mb.ow_x_rvalid = x_hit[0] | x_hit[1];
    assign mb.ow_p_rdata  = p_hit[0] ? mb.iw_mem_rdata[0] :
                            p_hit[1] ? mb.iw_mem_rdata[1] : p_hold_q;
    assign mb.ow_x_rdata  = x_hit[0] ? mb.iw_mem_rdata[0] :
                            x_hit[1] ? mb.iw_mem_rdata[1] : x_hold_q;

    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            p_hold_q <= '0;
            x_hold_q <= '0;
        end else begin
            if (mb.ow_p_rvalid) p_hold_q <= mb.ow_p_rdata;
            if (mb.ow_x_rvalid) x_hold_q <= mb.ow_x_rdata;
        end
    end

endmodule

// File: tb/tb_memarb2.sv
// Directed table-driven bench for memarb2 plus hand sequences for starvation,
// back-to-back reads and reset mid-read. Works with or without MEMARB_STARVE_EN.
module tb_memarb2;
    import memarb2_pkg::*;

    localparam int unsigned STARVE = 8;

    logic iw_clk;
    logic iw_rst;
    int   checks;
    int   errors;

    memarb2_if bus ();

    memarb2 #(.STARVE_MAX(STARVE)) dut (
        .iw_clk (iw_clk),
        .iw_rst (iw_rst),
        .mb     (bus)
    );

    initial begin
        iw_clk = 1'b0;
        forever #5 iw_clk = ~iw_clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

    function automatic logic [31:0] mdata(int unsigned b, logic [15:0] a);
        return 32'hD000_0000 | (32'(b) << 16) | 32'(a);
    endfunction

    // Bank model: one-cycle read latency, data derived from bank and address
    always @(posedge iw_clk) begin
        for (int b = 0; b < 2; b++) begin
            if (bus.ow_mem_en[b] && !bus.ow_mem_we[b])
                bus.iw_mem_rdata[b] <= mdata(32'(b), bus.ow_mem_addr[b]);
        end
    end

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic drive_p(logic req, logic mp, logic we, logic [15:0] a, logic [31:0] wd);
        bus.iw_p_req = req; bus.iw_p_mp = mp; bus.iw_p_we = we;
        bus.iw_p_addr = a;  bus.iw_p_wdata = wd;
    endtask

    task automatic drive_x(logic req, logic mp, logic we, logic [15:0] a, logic [31:0] wd);
        bus.iw_x_req = req; bus.iw_x_mp = mp; bus.iw_x_we = we;
        bus.iw_x_addr = a;  bus.iw_x_wdata = wd;
    endtask

    typedef struct {
        logic        p_req, p_mp, p_we;
        logic [15:0] p_addr;
        logic [31:0] p_wdata;
        logic        x_req, x_mp, x_we;
        logic [15:0] x_addr;
        logic [31:0] x_wdata;
        logic        e_stall, e_gnt;
        logic [1:0]  e_en, e_we;      // {bank1, bank0}
        logic [15:0] e_a0, e_a1;
        logic [31:0] e_wd0, e_wd1;
        logic        e_prv, e_xrv;
        logic [31:0] e_prd, e_xrd;
    } vec_t;

    vec_t vt [11];

    initial begin
        checks = 0;
        errors = 0;

        vt[0]  = '{0,0,0,16'h0,32'h0,     0,0,0,16'h0,32'h0,
                   0,0,2'b00,2'b00,16'h0,16'h0,32'h0,32'h0,       0,0,32'h0,32'h0};
        vt[1]  = '{1,0,0,16'h10,32'h0,    1,1,1,16'h20,32'hBEEF,
                   0,1,2'b11,2'b10,16'h10,16'h20,32'h0,32'hBEEF,  0,0,32'h0,32'h0};
        vt[2]  = '{0,0,0,16'h0,32'h0,     0,0,0,16'h0,32'h0,
                   0,0,2'b00,2'b00,16'h0,16'h0,32'h0,32'h0,       1,0,32'hD000_0010,32'h0};
        vt[3]  = '{1,0,1,16'h44,32'h1234, 1,1,0,16'h33,32'h0,
                   0,1,2'b11,2'b01,16'h44,16'h33,32'h1234,32'h0,  0,0,32'hD000_0010,32'h0};
        vt[4]  = '{1,1,0,16'h05,32'h0,    1,1,0,16'h06,32'h0,
                   0,0,2'b10,2'b00,16'h0,16'h05,32'h0,32'h0,      0,1,32'hD000_0010,32'hD001_0033};
        vt[5]  = '{0,0,0,16'h0,32'h0,     1,1,0,16'h06,32'h0,
                   0,1,2'b10,2'b00,16'h0,16'h06,32'h0,32'h0,      1,0,32'hD001_0005,32'hD001_0033};
        vt[6]  = '{1,1,0,16'h07,32'h0,    1,0,0,16'h08,32'h0,
                   0,1,2'b11,2'b00,16'h08,16'h07,32'h0,32'h0,     0,1,32'hD001_0005,32'hD001_0006};
        vt[7]  = '{0,0,0,16'h0,32'h0,     0,0,0,16'h0,32'h0,
                   0,0,2'b00,2'b00,16'h0,16'h0,32'h0,32'h0,       1,1,32'hD001_0007,32'hD000_0008};
        vt[8]  = '{0,0,0,16'h0,32'h0,     0,0,0,16'h0,32'h0,
                   0,0,2'b00,2'b00,16'h0,16'h0,32'h0,32'h0,       0,0,32'hD001_0007,32'hD000_0008};
        vt[9]  = '{1,0,1,16'h50,32'hAAAA, 1,0,1,16'h51,32'h5555,
                   0,0,2'b01,2'b01,16'h50,16'h0,32'hAAAA,32'h0,   0,0,32'hD001_0007,32'hD000_0008};
        vt[10] = '{0,0,0,16'h0,32'h0,     1,0,1,16'h51,32'h5555,
                   0,1,2'b01,2'b01,16'h51,16'h0,32'h5555,32'h0,   0,0,32'hD001_0007,32'hD000_0008};

        // Reset
        iw_rst = 1'b0;
        drive_p(0, 0, 0, '0, '0);
        drive_x(1, 0, 0, 16'h77, '0);
        tick();
        tick();
        @(negedge iw_clk);
        chk1("rst x_gnt",   bus.ow_x_gnt,     1'b0);
        chk1("rst en0",     bus.ow_mem_en[0], 1'b0);
        chk1("rst p_rvalid", bus.ow_p_rvalid, 1'b0);
        chk1("rst x_rvalid", bus.ow_x_rvalid, 1'b0);
        chk32("rst p_rdata", bus.ow_p_rdata,  32'h0);
        chk32("rst x_rdata", bus.ow_x_rdata,  32'h0);
        drive_x(0, 0, 0, '0, '0);
        iw_rst = 1'b1;
        tick();

        // Table of single-cycle vectors
        for (int i = 0; i < 11; i++) begin
            drive_p(vt[i].p_req, vt[i].p_mp, vt[i].p_we, vt[i].p_addr, vt[i].p_wdata);
            drive_x(vt[i].x_req, vt[i].x_mp, vt[i].x_we, vt[i].x_addr, vt[i].x_wdata);
            @(negedge iw_clk);
            chk1($sformatf("row%0d stall", i), bus.ow_p_stall, vt[i].e_stall);
            chk1($sformatf("row%0d gnt", i), bus.ow_x_gnt, vt[i].e_gnt);
            for (int b = 0; b < 2; b++) begin
                chk1($sformatf("row%0d en%0d", i, b), bus.ow_mem_en[b], vt[i].e_en[b]);
                chk1($sformatf("row%0d we%0d", i, b), bus.ow_mem_we[b], vt[i].e_we[b]);
            end
            if (vt[i].e_en[0]) chk32($sformatf("row%0d addr0", i), 32'(bus.ow_mem_addr[0]), 32'(vt[i].e_a0));
            if (vt[i].e_en[1]) chk32($sformatf("row%0d addr1", i), 32'(bus.ow_mem_addr[1]), 32'(vt[i].e_a1));
            if (vt[i].e_we[0]) chk32($sformatf("row%0d wdata0", i), bus.ow_mem_wdata[0], vt[i].e_wd0);
            if (vt[i].e_we[1]) chk32($sformatf("row%0d wdata1", i), bus.ow_mem_wdata[1], vt[i].e_wd1);
            chk1($sformatf("row%0d p_rvalid", i), bus.ow_p_rvalid, vt[i].e_prv);
            chk1($sformatf("row%0d x_rvalid", i), bus.ow_x_rvalid, vt[i].e_xrv);
            chk32($sformatf("row%0d p_rdata", i), bus.ow_p_rdata, vt[i].e_prd);
            chk32($sformatf("row%0d x_rdata", i), bus.ow_x_rdata, vt[i].e_xrd);
            tick();
        end
        drive_p(0, 0, 0, '0, '0);
        drive_x(0, 0, 0, '0, '0);
        tick();

        // Continuous conflict on bank1
        drive_p(1, 1, 0, 16'h40, '0);
        drive_x(1, 1, 0, 16'h41, '0);
`ifdef MEMARB_STARVE_EN
        for (int c = 1; c <= int'(STARVE) + 1; c++) begin
            @(negedge iw_clk);
            chk1($sformatf("starve c%0d gnt", c), bus.ow_x_gnt, c == int'(STARVE) + 1);
            chk1($sformatf("starve c%0d stall", c), bus.ow_p_stall, c == int'(STARVE) + 1);
            if (c > 1) chk1($sformatf("starve c%0d p_rvalid", c), bus.ow_p_rvalid, 1'b1);
            tick();
        end
        drive_x(0, 0, 0, '0, '0);
        @(negedge iw_clk);
        chk1("starve x_rvalid", bus.ow_x_rvalid, 1'b1);
        chk32("starve x_rdata", bus.ow_x_rdata, mdata(1, 16'h41));
        chk1("starve p_rvalid after stall", bus.ow_p_rvalid, 1'b0);
        drive_p(0, 0, 0, '0, '0);
        tick();
`else
        for (int c = 1; c <= 50; c++) begin
            @(negedge iw_clk);
            chk1($sformatf("strict c%0d gnt", c), bus.ow_x_gnt, 1'b0);
            chk1($sformatf("strict c%0d stall", c), bus.ow_p_stall, 1'b0);
            tick();
        end
        drive_p(0, 0, 0, '0, '0);
        @(negedge iw_clk);
        chk1("strict gnt after p drop", bus.ow_x_gnt, 1'b1);
        tick();
        drive_x(0, 0, 0, '0, '0);
        @(negedge iw_clk);
        chk1("strict x_rvalid", bus.ow_x_rvalid, 1'b1);
        chk32("strict x_rdata", bus.ow_x_rdata, mdata(1, 16'h41));
        tick();
`endif
        tick();

        // Back-to-back pipeline reads alternating banks
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive_p(1, 1'(i % 2), 0, 16'(i), '0);
            else       drive_p(0, 0, 0, '0, '0);
            @(negedge iw_clk);
            chk1($sformatf("b2b%0d stall", i), bus.ow_p_stall, 1'b0);
            if (i > 0) begin
                chk1($sformatf("b2b%0d p_rvalid", i), bus.ow_p_rvalid, 1'b1);
                chk32($sformatf("b2b%0d p_rdata", i), bus.ow_p_rdata,
                      mdata(32'((i - 1) % 2), 16'(i - 1)));
            end
            tick();
        end

        // Agent read granted, then reset the following cycle
        drive_x(1, 0, 0, 16'h60, '0);
        @(negedge iw_clk);
        chk1("rstmid gnt", bus.ow_x_gnt, 1'b1);
        tick();
        iw_rst = 1'b0;
        drive_x(1, 1, 0, 16'h61, '0);
        drive_p(1, 0, 0, 16'h62, '0);
        @(negedge iw_clk);
        chk1("rstmid x_rvalid", bus.ow_x_rvalid, 1'b0);
        chk1("rstmid x_gnt",    bus.ow_x_gnt,    1'b0);
        chk1("rstmid stall",    bus.ow_p_stall,  1'b0);
        chk1("rstmid en0",      bus.ow_mem_en[0], 1'b0);
        chk1("rstmid en1",      bus.ow_mem_en[1], 1'b0);
        tick();
        iw_rst = 1'b1;
        drive_p(0, 0, 0, '0, '0);
        drive_x(0, 0, 0, '0, '0);
        @(negedge iw_clk);
        chk1("postrst x_rvalid", bus.ow_x_rvalid, 1'b0);
        chk1("postrst p_rvalid", bus.ow_p_rvalid, 1'b0);
        chk32("postrst p_rdata", bus.ow_p_rdata, 32'h0);
        chk32("postrst x_rdata", bus.ow_x_rdata, 32'h0);
        tick();

        // After reset a conflict goes to the pipeline again
        drive_p(1, 0, 0, 16'h70, '0);
        drive_x(1, 0, 0, 16'h71, '0);
        @(negedge iw_clk);
        chk1("postrst conflict gnt", bus.ow_x_gnt, 1'b0);
        chk1("postrst conflict stall", bus.ow_p_stall, 1'b0);
        tick();
        drive_p(0, 0, 0, '0, '0);
        @(negedge iw_clk);
        chk1("postrst agent gnt", bus.ow_x_gnt, 1'b1);
        tick();
        drive_x(0, 0, 0, '0, '0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
